pendulum_thdot_driver: RTL

PENDULUM_THDOT_DRIVER -- requirements
Module: pendulum_thdot_driver

---
 rtl/pendulum_thdot_driver_if.sv | 33 +++
 rtl/pendulum_thdot_driver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pendulum_thdot_driver_if.sv
// Bus between the thdot driver, its step source, the thdot compute unit and
// the result sink. The slave modport is the driver's view of the bus.
interface pendulum_thdot_driver_if;
  logic        i_step_valid;
  logic        o_step_ready;
  logic [31:0] i_step_th;
  logic [31:0] i_step_thdot;
  logic [31:0] i_step_tor;
  logic        o_cmp_ena;
  logic [31:0] o_cmp_th;
  logic [31:0] o_cmp_thdot;
  logic [31:0] o_cmp_tor;
  logic        i_cmp_valid;
  logic [31:0] i_cmp_thdot;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [31:0] o_res_thdot;
  logic [2:0]  o_res_flags;

  modport slave (
    input  i_step_valid, i_step_th, i_step_thdot, i_step_tor,
    input  i_cmp_valid, i_cmp_thdot, i_res_ready,
    output o_step_ready, o_cmp_ena, o_cmp_th, o_cmp_thdot, o_cmp_tor,
    output o_res_valid, o_res_thdot, o_res_flags
  );

  modport master (
    output i_step_valid, i_step_th, i_step_thdot, i_step_tor,
    output i_cmp_valid, i_cmp_thdot, i_res_ready,
    input  o_step_ready, o_cmp_ena, o_cmp_th, o_cmp_thdot, o_cmp_tor,
    input  o_res_valid, o_res_thdot, o_res_flags
  );
endinterface

// File: rtl/pendulum_thdot_driver.sv
// Launches one thdot computation per accepted step, waits (with timeout) for
// the result, clips it to [-8.0, +8.0] and holds it until the sink accepts.
module pendulum_thdot_driver #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned GAP_CYC     = 2
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  pendulum_thdot_driver_if.slave io_drv
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [30:0] MAG_8P0  = 31'h41000000;

  // Returns {timeout, nan, clipped, value}; NaN collapses to +0.0.
  function automatic logic [34:0] clip_thdot(input logic [31:0] x);
    logic [34:0] r;
    if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
      r = {3'b010, 32'h00000000};
    end else if (x[30:0] > MAG_8P0) begin
      r = {3'b001, x[31], MAG_8P0};
    end else begin
      r = {3'b000, x};
    end
    return r;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;
  logic [34:0] w_clip;

  logic        r_step_ready;
  logic        r_cmp_ena;
  logic [31:0] r_cmp_th;
  logic [31:0] r_cmp_thdot;
  logic [31:0] r_cmp_tor;
  logic        r_res_valid;
  logic [31:0] r_res_thdot;
  logic [2:0]  r_res_flags;

  assign w_clip = clip_thdot(io_drv.i_cmp_thdot);

  // State and shared WAIT/GAP cycle counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and event decode; a result beats a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_drv.i_step_valid && r_step_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
        w_cnt_nxt = 16'd0;
      end
      ST_RUN: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = 16'd0;
      end
      ST_WAIT: begin
        if (io_drv.i_cmp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = 16'd0;
        end else if (r_cnt == TO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      ST_HOLD: begin
        if (io_drv.i_res_ready) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_HOLD;
        end
        w_cnt_nxt = 16'd0;
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Registered handshake/enable outputs follow the upcoming state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_ready <= 1'b0;
      r_cmp_ena    <= 1'b0;
      r_res_valid  <= 1'b0;
    end else begin
      r_step_ready <= (w_state_nxt == ST_IDLE);
      r_cmp_ena    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_WAIT);
      r_res_valid  <= (w_state_nxt == ST_HOLD);
    end
  end

  // Operand capture on step acceptance; held until the next step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmp_th    <= 32'h00000000;
      r_cmp_thdot <= 32'h00000000;
      r_cmp_tor   <= 32'h00000000;
    end else if (w_accept) begin
      r_cmp_th    <= io_drv.i_step_th;
      r_cmp_thdot <= io_drv.i_step_thdot;
      r_cmp_tor   <= io_drv.i_step_tor;
    end
  end

  // Result capture: clipped compute result or timeout marker.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_thdot <= 32'h00000000;
      r_res_flags <= 3'b000;
    end else if (w_capture) begin
      r_res_thdot <= w_clip[31:0];
      r_res_flags <= w_clip[34:32];
    end else if (w_timeout) begin
      r_res_thdot <= 32'h00000000;
      r_res_flags <= 3'b100;
    end
  end

  assign io_drv.o_step_ready = r_step_ready;
  assign io_drv.o_cmp_ena    = r_cmp_ena;
  assign io_drv.o_cmp_th     = r_cmp_th;
  assign io_drv.o_cmp_thdot  = r_cmp_thdot;
  assign io_drv.o_cmp_tor    = r_cmp_tor;
  assign io_drv.o_res_valid  = r_res_valid;
  assign io_drv.o_res_thdot  = r_res_thdot;
  assign io_drv.o_res_flags  = r_res_flags;

endmodule
